// File: rtl/apu_sweep_multi.sv
// rtl/apu_sweep_multi.sv - multi-channel APU period sweep unit
//
// Holds NCH independent sweep channels. Each channel has a working period,
// a sweep divider, a reload flag and a latched sweep configuration. On
// half-frame ticks, each channel's period is adjusted by a shifted copy of
// itself.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   halfframe      one-cycle half-frame tick shared by all channels
//   period_wr      per-channel strobe loading period_in into the working period
//   period_in      flattened period write data, channel i at [i*PW +: PW]
//   sweep_wr       per-channel sweep-register write strobe
//   sweep_en       sweep enable, latched on sweep_wr
//   sweep_neg      negate mode, latched on sweep_wr
//   sweep_period   divider reload value, latched on sweep_wr
//   sweep_shift    shift count, latched on sweep_wr
//   current_period working period per channel
//   mute           per-channel mute (combinational from state)
//   sweep_tick     one-cycle pulse when the sweep updated a channel's period
module apu_sweep_multi #(
   parameter int             NCH      = 2,
   parameter int             PW       = 11,
   parameter int             DW       = 3,
   parameter int             SW       = 3,
   parameter logic [NCH-1:0] NEG_ONES = 2'b01,
   parameter int             MUTE_MIN = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halfframe,
   input  logic [NCH-1:0]    period_wr,
   input  logic [NCH*PW-1:0] period_in,
   input  logic [NCH-1:0]    sweep_wr,
   input  logic [NCH-1:0]    sweep_en,
   input  logic [NCH-1:0]    sweep_neg,
   input  logic [NCH*DW-1:0] sweep_period,
   input  logic [NCH*SW-1:0] sweep_shift,
   output logic [NCH*PW-1:0] current_period,
   output logic [NCH-1:0]    mute,
   output logic [NCH-1:0]    sweep_tick
);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [PW-1:0] cur;
      logic [DW-1:0] div;
      logic          reload;
      logic          en_q;
      logic          neg_q;
      logic [DW-1:0] per_q;
      logic [SW-1:0] sh_q;
      logic          tick_q;

      logic [PW-1:0] chg;
      logic [PW:0]   sum;
      logic [PW:0]   dif;
      logic [PW:0]   target;
      logic          ch_mute;
      logic          do_update;

      // Target is always computed so mute can track it regardless of enable.
      assign chg    = cur >> sh_q;
      assign sum    = {1'b0, cur} + {1'b0, chg};
      // Ones'-complement channels subtract one extra.
      assign dif    = {1'b0, cur} - {1'b0, chg} - {{PW{1'b0}}, NEG_ONES[i]};
      assign target = neg_q ? dif : sum;

      // Only an add-mode carry mutes; a negate-mode borrow is ignored.
      assign ch_mute   = (cur < PW'(MUTE_MIN)) || (!neg_q && target[PW]);
      assign do_update = halfframe && (div == '0) && en_q && (sh_q != '0) && !ch_mute;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cur    <= '0;
            div    <= '0;
            reload <= 1'b0;
            en_q   <= 1'b0;
            neg_q  <= 1'b0;
            per_q  <= '0;
            sh_q   <= '0;
            tick_q <= 1'b0;
         end else begin
            // A direct period write takes priority over a sweep update.
            if (period_wr[i]) begin
               cur <= period_in[i*PW +: PW];
            end else if (do_update) begin
               cur <= target[PW-1:0];
            end
            tick_q <= do_update && !period_wr[i];

            if (halfframe) begin
               if ((div == '0) || reload) begin
                  div    <= per_q;
                  reload <= 1'b0;
               end else begin
                  div <= div - DW'(1);
               end
            end

            // Placed after the half-frame step so that a same-edge write
            // leaves reload set for the next half-frame.
            if (sweep_wr[i]) begin
               en_q   <= sweep_en[i];
               neg_q  <= sweep_neg[i];
               per_q  <= sweep_period[i*DW +: DW];
               sh_q   <= sweep_shift[i*SW +: SW];
               reload <= 1'b1;
            end
         end
      end

      assign current_period[i*PW +: PW] = cur;
      assign mute[i]                    = ch_mute;
      assign sweep_tick[i]              = tick_q;
   end

endmodule
